bot_port_master: RTL and testbench

BOT_PORT_MASTER -- requirements
Module: bot_port_master

---
 rtl/bot_port_pkg.sv | 48 ++++
 rtl/bot_steer_lut.sv | 21 ++
 rtl/bot_port_master.sv | 190 +++++++++++++++++++
 tb/tb_bot_port_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bot_port_pkg.sv
// Shared definitions for the line-follower bus master: I/O port map, steering command bytes, sequencer states.
// Display port constants and states exist only when BOT_PORT_MASTER_DISPLAY_EN is defined.
package bot_port_pkg;

  localparam logic [7:0] PORT_LED    = 8'h02;
  localparam logic [7:0] PORT_MOTOR  = 8'h09;
  localparam logic [7:0] PORT_X      = 8'h0A;
  localparam logic [7:0] PORT_Y      = 8'h0B;
  localparam logic [7:0] PORT_SENSOR = 8'h0D;
`ifdef BOT_PORT_MASTER_DISPLAY_EN
  localparam logic [7:0] PORT_DISP_XH = 8'h03;
  localparam logic [7:0] PORT_DISP_XL = 8'h04;
  localparam logic [7:0] PORT_DISP_YH = 8'h05;
  localparam logic [7:0] PORT_DISP_YL = 8'h06;
`endif

  localparam logic [7:0] CMD_FWD    = 8'h33;
  localparam logic [7:0] CMD_LEFT   = 8'h13;
  localparam logic [7:0] CMD_RIGHT  = 8'h31;
  localparam logic [7:0] CMD_SEARCH = 8'h30;
  localparam logic [7:0] CMD_STOP   = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACK,
    ST_RD_SENS,
    ST_RD_X,
    ST_RD_Y,
    ST_WR_MOT,
    ST_WR_LED,
    ST_WR_STOP
`ifdef BOT_PORT_MASTER_DISPLAY_EN
    ,
    ST_WR_D3,
    ST_WR_D2,
    ST_WR_D1,
    ST_WR_D0
`endif
  } state_t;

  // State whose write closes a service sequence and bumps sample_count.
`ifdef BOT_PORT_MASTER_DISPLAY_EN
  localparam state_t ST_LAST = ST_WR_D0;
`else
  localparam state_t ST_LAST = ST_WR_LED;
`endif

endpackage

// File: rtl/bot_steer_lut.sv
// Combinational map from the {L,C,R} line sensor bits to the motor command byte.
// Zero latency; no flow control.
module bot_steer_lut
  import bot_port_pkg::*;
(
  input  logic [2:0] sensor,
  output logic [7:0] cmd
);

  always_comb begin
    cmd = CMD_STOP;
    case (sensor)
      3'b010:         cmd = CMD_FWD;
      3'b100, 3'b110: cmd = CMD_LEFT;
      3'b001, 3'b011: cmd = CMD_RIGHT;
      3'b000:         cmd = CMD_SEARCH;
      default:        cmd = CMD_STOP;
    endcase
  end

endmodule

// File: rtl/bot_port_master.sv
// Line-follower I/O bus master: acks the responder interrupt, reads sensor/X/Y, writes motor, LED (and display with BOT_PORT_MASTER_DISPLAY_EN).
// Registered outputs, 9-cycle sequence (13 with display); no backpressure, one bus access per cycle.
module bot_port_master
  import bot_port_pkg::*;
(
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic       enable,
  input  logic       interrupt,
  output logic       interrupt_ack,
  output logic [7:0] port_id,
  output logic       read_strobe,
  output logic       write_strobe,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       busy,
  output logic [7:0] sample_count
);

  state_t     state, state_nxt;
  logic       rd_phase, rd_phase_nxt;
  logic       en_q;
  logic       stop_pend, stop_pend_nxt;
  logic       stop_req;
  logic [7:0] sensor_q;
`ifdef BOT_PORT_MASTER_DISPLAY_EN
  logic [7:0] x_q;
  logic [7:0] y_q;
`endif
  logic [7:0] steer_cmd;
  logic [7:0] port_id_nxt;
  logic [7:0] out_port_nxt;
  logic       rd_nxt;
  logic       wr_nxt;
  logic       ack_nxt;

  bot_steer_lut u_steer (
    .sensor (sensor_q[2:0]),
    .cmd    (steer_cmd)
  );

  // A falling enable is remembered until the sequencer is back in IDLE.
  assign stop_req = stop_pend | (en_q & ~enable);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    rd_phase_nxt  = 1'b0;
    stop_pend_nxt = stop_req;
    port_id_nxt   = port_id;
    out_port_nxt  = out_port;
    rd_nxt        = 1'b0;
    wr_nxt        = 1'b0;
    ack_nxt       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (stop_req)
          state_nxt = ST_WR_STOP;
        else if (interrupt && enable)
          state_nxt = ST_ACK;
      end
      ST_ACK: state_nxt = ST_RD_SENS;
      ST_RD_SENS: begin
        rd_phase_nxt = ~rd_phase;
        state_nxt    = rd_phase ? ST_RD_X : ST_RD_SENS;
      end
      ST_RD_X: begin
        rd_phase_nxt = ~rd_phase;
        state_nxt    = rd_phase ? ST_RD_Y : ST_RD_X;
      end
      ST_RD_Y: begin
        rd_phase_nxt = ~rd_phase;
        state_nxt    = rd_phase ? ST_WR_MOT : ST_RD_Y;
      end
      ST_WR_MOT: state_nxt = ST_WR_LED;
`ifdef BOT_PORT_MASTER_DISPLAY_EN
      ST_WR_LED: state_nxt = ST_WR_D3;
      ST_WR_D3:  state_nxt = ST_WR_D2;
      ST_WR_D2:  state_nxt = ST_WR_D1;
      ST_WR_D1:  state_nxt = ST_WR_D0;
      ST_WR_D0:  state_nxt = ST_IDLE;
`else
      ST_WR_LED: state_nxt = ST_IDLE;
`endif
      ST_WR_STOP: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_WR_STOP)
      stop_pend_nxt = 1'b0;

    // Bus outputs are decoded from the next state so they leave flops aligned with it.
    case (state_nxt)
      ST_ACK: ack_nxt = 1'b1;
      ST_RD_SENS: begin
        port_id_nxt = PORT_SENSOR;
        rd_nxt      = ~rd_phase_nxt;
      end
      ST_RD_X: begin
        port_id_nxt = PORT_X;
        rd_nxt      = ~rd_phase_nxt;
      end
      ST_RD_Y: begin
        port_id_nxt = PORT_Y;
        rd_nxt      = ~rd_phase_nxt;
      end
      ST_WR_MOT: begin
        port_id_nxt  = PORT_MOTOR;
        out_port_nxt = steer_cmd;
        wr_nxt       = 1'b1;
      end
      ST_WR_LED: begin
        port_id_nxt  = PORT_LED;
        out_port_nxt = sensor_q;
        wr_nxt       = 1'b1;
      end
`ifdef BOT_PORT_MASTER_DISPLAY_EN
      ST_WR_D3: begin
        port_id_nxt  = PORT_DISP_XH;
        out_port_nxt = {4'h0, x_q[7:4]};
        wr_nxt       = 1'b1;
      end
      ST_WR_D2: begin
        port_id_nxt  = PORT_DISP_XL;
        out_port_nxt = {4'h0, x_q[3:0]};
        wr_nxt       = 1'b1;
      end
      ST_WR_D1: begin
        port_id_nxt  = PORT_DISP_YH;
        out_port_nxt = {4'h0, y_q[7:4]};
        wr_nxt       = 1'b1;
      end
      ST_WR_D0: begin
        port_id_nxt  = PORT_DISP_YL;
        out_port_nxt = {4'h0, y_q[3:0]};
        wr_nxt       = 1'b1;
      end
`endif
      ST_WR_STOP: begin
        port_id_nxt  = PORT_MOTOR;
        out_port_nxt = CMD_STOP;
        wr_nxt       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state         <= ST_IDLE;
      rd_phase      <= 1'b0;
      en_q          <= 1'b0;
      stop_pend     <= 1'b0;
      sensor_q      <= 8'h00;
`ifdef BOT_PORT_MASTER_DISPLAY_EN
      x_q           <= 8'h00;
      y_q           <= 8'h00;
`endif
      port_id       <= 8'h00;
      out_port      <= 8'h00;
      read_strobe   <= 1'b0;
      write_strobe  <= 1'b0;
      interrupt_ack <= 1'b0;
      sample_count  <= 8'h00;
    end else begin
      state         <= state_nxt;
      rd_phase      <= rd_phase_nxt;
      en_q          <= enable;
      stop_pend     <= stop_pend_nxt;
      port_id       <= port_id_nxt;
      out_port      <= out_port_nxt;
      read_strobe   <= rd_nxt;
      write_strobe  <= wr_nxt;
      interrupt_ack <= ack_nxt;
      // Read data is valid in the second cycle of each read.
      if (state == ST_RD_SENS && rd_phase)
        sensor_q <= in_port;
`ifdef BOT_PORT_MASTER_DISPLAY_EN
      if (state == ST_RD_X && rd_phase)
        x_q <= in_port;
      if (state == ST_RD_Y && rd_phase)
        y_q <= in_port;
`endif
      if (state == ST_LAST)
        sample_count <= sample_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_bot_port_master.sv
// Scoreboarded random bench for bot_port_master with a registered-read responder model.
module tb_bot_port_master;

  logic       sysclk = 1'b0;
  logic       sysreset;
  logic       enable;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       busy;
  logic [7:0] sample_count;

  always #5 sysclk = ~sysclk;

  bot_port_master dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .enable        (enable),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .busy          (busy),
    .sample_count  (sample_count)
  );

  typedef struct {
    int         kind;   // 0 ack, 1 read, 2 write
    logic [7:0] port;
    logic [7:0] data;
    bit         last;
  } ev_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] x;
    logic [7:0] y;
  } vals_t;

  ev_t   expq[$];
  vals_t pend[$];
  vals_t cur;
  int    n_assert  = 0;
  int    n_fail    = 0;
  int    model_cnt = 0;
  int    n_rd_x    = 0;
  int    n_rd_y    = 0;
  bit    arm_rst   = 0;
  bit    rst_done  = 0;
  bit    post_rst  = 0;
  bit    prev_rd   = 0;
  logic [7:0] prev_port = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Steering rule: centred -> forward, both edges -> stop, one edge -> turn toward it, none -> search.
  function automatic logic [7:0] steer_ref(input logic [2:0] s);
    logic l, c, r;
    l = s[2]; c = s[1]; r = s[0];
    if (c && !l && !r) return 8'h33;
    if (l && r)        return 8'h00;
    if (l)             return 8'h13;
    if (r)             return 8'h31;
    return 8'h30;
  endfunction

  function automatic logic [7:0] regval(input logic [7:0] p);
    case (p)
      8'h0D:   return cur.s;
      8'h0A:   return cur.x;
      8'h0B:   return cur.y;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic vals_t rand_vals();
    vals_t v;
    v.s = 8'($urandom);
    v.x = 8'($urandom);
    v.y = 8'($urandom);
    return v;
  endfunction

  task automatic push_ev(input int k, input logic [7:0] p, input logic [7:0] d, input bit l);
    ev_t e;
    e.kind = k; e.port = p; e.data = d; e.last = l;
    expq.push_back(e);
  endtask

  task automatic push_seq(input vals_t v);
    push_ev(0, 8'h00, 8'h00, 0);
    push_ev(1, 8'h0D, 8'h00, 0);
    push_ev(1, 8'h0A, 8'h00, 0);
    push_ev(1, 8'h0B, 8'h00, 0);
    push_ev(2, 8'h09, steer_ref(v.s[2:0]), 0);
`ifdef BOT_PORT_MASTER_DISPLAY_EN
    push_ev(2, 8'h02, v.s, 0);
    push_ev(2, 8'h03, {4'h0, v.x[7:4]}, 0);
    push_ev(2, 8'h04, {4'h0, v.x[3:0]}, 0);
    push_ev(2, 8'h05, {4'h0, v.y[7:4]}, 0);
    push_ev(2, 8'h06, {4'h0, v.y[3:0]}, 1);
`else
    push_ev(2, 8'h02, v.s, 1);
`endif
  endtask

  task automatic post_seq(input vals_t v);
    pend.push_back(v);
    push_seq(v);
    interrupt = 1'b1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 200; i++) begin
      if (!interrupt) return;
      @(posedge sysclk); #2;
    end
    fail_now("ack_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge sysclk); #2;
      if (expq.size() == 0 && !busy && !interrupt) done = 1;
    end
    if (!done) begin
      fail_now("drain_timeout");
      expq.delete();
    end
    repeat (2) @(posedge sysclk);
    #2;
    chk("count_drain", sample_count, model_cnt & 255);
  endtask

  // Monitor, scoreboard and responder, all sampled on the falling edge.
  initial begin
    ev_t e;
    int  n_str;
    int  k;
    forever begin
      @(negedge sysclk);
      if (post_rst) begin
        chk("rst_wr_strobe", write_strobe, 0);
        chk("rst_rd_strobe", read_strobe, 0);
        chk("rst_ack", interrupt_ack, 0);
        chk("rst_port_id", port_id, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", sample_count, 0);
        sysreset = 1'b0;
        post_rst = 0;
        prev_rd  = 0;
      end
      n_str = int'(read_strobe) + int'(write_strobe) + int'(interrupt_ack);
      if (n_str > 1) fail_now("strobe_exclusive");
      if (prev_rd) begin
        chk("rd_hold_strobe", read_strobe, 0);
        chk("rd_hold_port", port_id, prev_port);
      end
      if (n_str != 0 && !sysreset) begin
        chk("busy_active", busy, 1);
        if (expq.size() == 0) begin
          fail_now("unexpected_access");
        end else begin
          e = expq.pop_front();
          k = interrupt_ack ? 0 : (read_strobe ? 1 : 2);
          chk("access_kind", k, e.kind);
          if (k != 0) chk("port_id", port_id, e.port);
          if (k == 2) chk("write_data", out_port, e.data);
          if (k == 0) begin
            chk("count_at_ack", sample_count, model_cnt & 255);
            interrupt = 1'b0;
            if (pend.size() == 0) fail_now("ack_without_request");
            else cur = pend.pop_front();
          end
          if (k == 1 && port_id == 8'h0A) n_rd_x++;
          if (k == 1 && port_id == 8'h0B) n_rd_y++;
          if (k == 2 && e.last) model_cnt++;
          if (k == 2 && port_id == 8'h09 && arm_rst) begin
            sysreset  = 1'b1;
            arm_rst   = 0;
            expq.delete();
            model_cnt = 0;
            post_rst  = 1;
            rst_done  = 1;
          end
        end
      end
      // Responder registers the read, so data appears only in the second read cycle.
      if (prev_rd) in_port = regval(prev_port);
      else         in_port = 8'($urandom);
      prev_rd   = read_strobe;
      prev_port = port_id;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vals_t v, v2;
    int    base;
    sysreset  = 1'b1;
    enable    = 1'b1;
    interrupt = 1'b0;
    in_port   = 8'h00;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("reset_port_id", port_id, 0);
    chk("reset_out_port", out_port, 0);
    chk("reset_rd", read_strobe, 0);
    chk("reset_wr", write_strobe, 0);
    chk("reset_ack", interrupt_ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", sample_count, 0);
    sysreset = 1'b0;
    @(posedge sysclk); #2;

    // Directed example sequence.
    v.s = 8'h02; v.x = 8'h5A; v.y = 8'hC3;
    post_seq(v);
    wait_ack();
    drain();
    chk("count_first", sample_count, 8'h01);

    // Every sensor combination, upper bits random.
    for (int s = 0; s < 8; s++) begin
      v = rand_vals();
      v.s[2:0] = 3'(s);
      post_seq(v);
      wait_ack();
    end
    drain();

    // Interrupt re-raised while the X read is in flight.
    base = n_rd_x;
    v = rand_vals();
    post_seq(v);
    for (int i = 0; i < 100 && n_rd_x == base; i++) begin
      @(posedge sysclk); #2;
    end
    if (n_rd_x == base) fail_now("rd_x_timeout");
    v2 = rand_vals();
    post_seq(v2);
    wait_ack();
    drain();

    // Enable dropped during the Y read, then interrupt raised while disabled.
    base = n_rd_y;
    v = rand_vals();
    post_seq(v);
    for (int i = 0; i < 100 && n_rd_y == base; i++) begin
      @(posedge sysclk); #2;
    end
    if (n_rd_y == base) fail_now("rd_y_timeout");
    enable = 1'b0;
    push_ev(2, 8'h09, 8'h00, 0);
    v2 = rand_vals();
    pend.push_back(v2);
    interrupt = 1'b1;
    repeat (60) @(posedge sysclk);
    #2;
    chk("irq_unacked_disabled", interrupt, 1);
    chk("stop_write_seen", expq.size(), 0);
    push_seq(v2);
    enable = 1'b1;
    wait_ack();
    drain();

    // Reset pulsed during the motor write.
    rst_done = 0;
    arm_rst  = 1;
    post_seq(rand_vals());
    for (int i = 0; i < 100 && !(rst_done && !post_rst); i++) begin
      @(posedge sysclk); #2;
    end
    if (!rst_done) begin
      fail_now("mid_reset_timeout");
      arm_rst = 0;
    end
    drain();

    // 256 back-to-back sequences wrap the counter.
    for (int n = 0; n < 256; n++) begin
      post_seq(rand_vals());
      wait_ack();
    end
    drain();
    chk("count_wrap", sample_count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
